// File: rtl/aes_block_serializer.sv
// Buffers 128-bit AES blocks and drains them LSB byte first into a UART.
// Optional trailing XOR checksum byte per block: AES_SER_CHECKSUM_EN.
module aes_block_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [127:0]                 blk_data,
  input  logic                         blk_valid,
  output logic                         blk_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  input  logic                         tx_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef AES_SER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_CSUM, S_CWAIT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_WAIT
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [127:0]   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [127:0]   shreg_q, shreg_d;
  logic [3:0]     byte_idx_q, byte_idx_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;
  logic           push, pop;
`ifdef AES_SER_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  assign blk_ready = count_q != FULL;
  assign push      = blk_valid && blk_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = (count_q != '0) || (state_q != S_IDLE);
  assign level     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
`ifdef AES_SER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shreg_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
`ifdef AES_SER_CHECKSUM_EN
          csum_d     = '0;
`endif
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        tx_data_d  = shreg_q[7:0];
        tx_start_d = 1'b1;
`ifdef AES_SER_CHECKSUM_EN
        csum_d     = csum_q ^ shreg_q[7:0];
`endif
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (byte_idx_q == 4'd15) begin
`ifdef AES_SER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
`endif
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            shreg_d    = {8'h00, shreg_q[127:8]};
            state_d    = S_SEND;
          end
        end
      end
`ifdef AES_SER_CHECKSUM_EN
      S_CSUM: begin
        tx_data_d  = csum_q;
        tx_start_d = 1'b1;
        state_d    = S_CWAIT;
      end
      S_CWAIT: begin
        if (tx_done) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= blk_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef AES_SER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
`ifdef AES_SER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Randomized bench for aes_block_serializer: byte-queue reference model,
// UART responder, and directed latency/fill/reset scenarios.
`timescale 1ns/1ps
module tb_aes_block_serializer;
  localparam int DEPTH = 4;
`ifdef AES_SER_CHECKSUM_EN
  localparam int BPB = 17;
`else
  localparam int BPB = 16;
`endif
  localparam logic [2:0] LFULL = 3'(DEPTH);

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_done;
  logic         busy;
  logic [2:0]   level;

  logic resp_done;
  logic spur_done;
  assign tx_done = resp_done | spur_done;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  int  sent_cnt = 0;
  int  blk_end_cnt = 0;
  bit  uart_busy = 1'b0;
  bit  prev_start = 1'b0;
  bit  hold_done = 1'b0;
  bit  dbl_done = 1'b0;
  int  resp_delay = 10;

  aes_block_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: every accepted block becomes its bytes, in order, on the UART.
  task automatic model_push(input logic [127:0] d);
    for (int i = 0; i < 16; i++) exp_q.push_back(d[8*i +: 8]);
`ifdef AES_SER_CHECKSUM_EN
    begin
      logic [7:0] cs;
      cs = 8'h00;
      for (int i = 0; i < 16; i++) cs = cs ^ d[8*i +: 8];
      exp_q.push_back(cs);
    end
`endif
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        sent_cnt = 0;
      end else if (blk_valid && blk_ready) begin
        model_push(blk_data);
      end
      if (tx_start) begin
        chk("start_one_cycle", 128'(prev_start), 128'(0));
        chk("uart_overlap", 128'(uart_busy), 128'(0));
        chk("byte_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_data", 128'(tx_data), 128'(e));
        end
        seen.push_back(tx_data);
        sent_cnt++;
        uart_busy = 1'b1;
      end
      if (resp_done && uart_busy) begin
        uart_busy = 1'b0;
        if (sent_cnt > 0 && sent_cnt % BPB == 0) blk_end_cnt++;
      end
      chk("ready_vs_level", 128'(blk_ready), 128'(level != LFULL));
      if (level != 3'd0) chk("busy_when_queued", 128'(busy), 128'(1));
      prev_start = tx_start;
    end
  end

  initial begin : responder
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        int n;
        n = (resp_delay != 0) ? resp_delay : int'($urandom_range(1, 6));
        repeat (n - 1) @(posedge clk);
        while (hold_done) @(posedge clk);
        @(posedge clk);
        #2 resp_done = 1'b1;
        @(posedge clk);
        #2;
        if (dbl_done) begin
          @(posedge clk);
          #2;
        end
        resp_done = 1'b0;
      end
    end
  end

  task automatic push_blk(input logic [127:0] d);
    int n;
    n = 0;
    blk_data  = d;
    blk_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!blk_ready && n < 5000);
    chk("push_accept", 128'(blk_ready), 128'(1));
    @(posedge clk);
    #2 blk_valid = 1'b0;
  endtask

  task automatic wait_blk_end(input int target);
    int n;
    n = 0;
    while (blk_end_cnt < target && n < 3000) begin
      @(negedge clk);
      #1 n++;
    end
    chk("blk_end_timeout", 128'(blk_end_cnt >= target), 128'(1));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while ((busy || uart_busy || exp_q.size() != 0) && n < 20000);
    chk(nm, 128'(busy || exp_q.size() != 0), 128'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc;
    int base;
    int tgt;
    int n;
    int steps;
    logic [2:0] prev_lvl;
    reset     = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_blk_ready", 128'(blk_ready), 128'(1));
    chk("rst_tx_start", 128'(tx_start), 128'(0));
    chk("rst_tx_data", 128'(tx_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_level", 128'(level), 128'(0));

    // Single known block: latency, byte order, busy release
    seen.delete();
    @(posedge clk);
    #2 blk_data = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    blk_valid = 1'b1;
    @(posedge clk);
    #2 blk_valid = 1'b0;
    @(negedge clk);
    chk("lat_e0_start", 128'(tx_start), 128'(0));
    chk("lat_e0_level", 128'(level), 128'(1));
    @(negedge clk);
    chk("lat_e1_start", 128'(tx_start), 128'(0));
    chk("lat_e1_level", 128'(level), 128'(0));
    chk("lat_e1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("lat_e2_start", 128'(tx_start), 128'(1));
    chk("lat_e2_data", 128'(tx_data), 128'(8'h01));
    wait_blk_end(blk_end_cnt + 1);
    chk("busy_at_last_done", 128'(busy), 128'(1));
    @(negedge clk);
    chk("busy_after_last_done", 128'(busy), 128'(0));
    chk("single_count", 128'(seen.size()), 128'(BPB));
    if (seen.size() >= 16) begin
      chk("single_b0", 128'(seen[0]), 128'(8'h01));
      chk("single_b7", 128'(seen[7]), 128'(8'h08));
      chk("single_b15", 128'(seen[15]), 128'(8'h10));
    end
`ifdef AES_SER_CHECKSUM_EN
    if (seen.size() >= 17) chk("single_csum", 128'(seen[16]), 128'(8'h10));
`endif

    // Spurious tx_done while idle
    @(posedge clk);
    #2 spur_done = 1'b1;
    @(posedge clk);
    #2 spur_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_idle_start", 128'(tx_start), 128'(0));
      chk("spur_idle_busy", 128'(busy), 128'(0));
    end

    // Fill with UART stalled
    resp_delay = 0;
    hold_done  = 1'b1;
    acc = 0;
    @(posedge clk);
    #2 blk_data = rnd128();
    blk_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (blk_ready) acc++;
      @(posedge clk);
      #2 blk_data = rnd128();
    end
    blk_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", 128'(acc), 128'(5));
    chk("fill_ready", 128'(blk_ready), 128'(0));
    chk("fill_level", 128'(level), 128'(4));
    hold_done = 1'b0;
    prev_lvl = level;
    steps = 0;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
      if (level != prev_lvl) begin
        chk("level_step", 128'(level), 128'(prev_lvl - 3'd1));
        prev_lvl = level;
        steps++;
      end
    end
    chk("drain_steps", 128'(steps), 128'(4));
    chk("drain_level", 128'(level), 128'(0));
    wait_idle("fill_drain");

    // Push coincident with an idle-state pop at count 2
    resp_delay = 2;
    hold_done  = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) push_blk(rnd128());
    repeat (3) @(negedge clk);
    chk("simul_setup_level", 128'(level), 128'(2));
    tgt = blk_end_cnt + 1;
    hold_done = 1'b0;
    wait_blk_end(tgt);
    @(posedge clk);
    #2 blk_data = rnd128();
    blk_valid = 1'b1;
    @(posedge clk);
    #2 blk_valid = 1'b0;
    @(negedge clk);
    chk("simul_level", 128'(level), 128'(2));
    wait_idle("simul_drain");

    // Reset during byte 7 with two blocks queued
    resp_delay = 3;
    @(posedge clk);
    #2;
    base = sent_cnt;
    for (int i = 0; i < 3; i++) push_blk(rnd128());
    n = 0;
    while (sent_cnt < base + 8 && n < 2000) begin
      @(negedge clk);
      #1 n++;
    end
    chk("rst_mid_reached", 128'(sent_cnt >= base + 8), 128'(1));
    chk("rst_mid_level", 128'(level), 128'(2));
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_start", 128'(tx_start), 128'(0));
    chk("rst_mid_lvl0", 128'(level), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_ready", 128'(blk_ready), 128'(1));
    repeat (30) @(negedge clk);
    chk("rst_stale_done_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #2 push_blk(rnd128());
    wait_idle("rst_recover");

    // Randomized traffic with spurious tx_done in S_SEND
    resp_delay = 0;
    for (int b = 0; b < 30; b++) begin
      dbl_done = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #2 push_blk(rnd128());
    end
    wait_idle("random_drain");
    dbl_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
